// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end.
//   fetch_entry_t : {pc, instr} pair as seen by ID (32-bit core build)
//   INSTR_BYTES   : fetch stride in bytes
//   NOP           : canonical bubble instruction (addi x0, x0, 0)
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int CORE_XLEN   = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [CORE_XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Generic circular buffer used both as the prefetch queue and as the in-flight
// PC FIFO. Push while full is accepted only when a pop happens in the same
// cycle. Flush empties the buffer in one cycle.
// Parameters: DEPTH (power of two, >= 2), WIDTH (entry width in bits)
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : drop all entries
//   push, push_data : write an entry at the tail
//   pop             : remove the head entry
//   head            : current head entry (undefined contents while empty)
//   count           : number of stored entries
//   full, empty     : occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // pointers and count, so resetting the array would only add reset fanout.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule : fetch_fifo

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end: credit-based prefetch queue with an in-order,
// multi-outstanding instruction-memory interface of arbitrary latency. Branch
// redirects flush the queue and mark in-flight responses for discard.
// Optional build macro: FETCH_BYPASS_EN -- when defined, a response arriving
// at an empty queue is presented to ID combinationally in the same cycle.
// Parameters: XLEN (PC/instr width), DEPTH (queue entries), RESET_PC
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   redirect_valid, redirect_pc     : taken branch from EX and its target
//   imem_req_valid/ready, imem_addr : fetch request channel
//   imem_rsp_valid, imem_rsp_data   : in-order fetch responses
//   id_valid/ready, id_pc, id_instr : head-of-queue handshake to ID
// -----------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]     CREDITS = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     credit_used;
  logic            q_full, q_empty, pcf_full, pcf_empty;
  entry_t          q_head, q_wdata;
  logic [XLEN-1:0] pcf_head;
  logic            accept, rsp_keep, rsp_drop;
  logic            q_push, q_pop;
  logic            bypass_hit, bypass_take;
  logic            unused_flags;

  // Every issued request reserves a queue slot until its instruction leaves,
  // so the queue can never overflow whatever the memory latency.
  assign credit_used    = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < CREDITS);
  assign imem_addr      = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response in the redirect cycle belongs to the old path: always dropped.
  assign rsp_keep = imem_rsp_valid && !redirect_valid && (discard == '0);
  assign rsp_drop = imem_rsp_valid && !rsp_keep;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = q_empty && rsp_keep;
`else
  assign bypass_hit = 1'b0;
`endif
  assign bypass_take = bypass_hit && id_ready;

  assign q_push   = rsp_keep && !bypass_take;
  assign q_pop    = !redirect_valid && !q_empty && id_ready;
  assign q_wdata  = '{pc: pcf_head, instr: imem_rsp_data};

  // Masked in the redirect cycle so ID never consumes a wrong-path instruction.
  assign id_valid = !reset && !redirect_valid && (!q_empty || bypass_hit);

  // NOTE: combinational outputs get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    id_pc    = '0;
    id_instr = '0;
    if (!q_empty) begin
      id_pc    = q_head.pc;
      id_instr = q_head.instr;
    end else if (bypass_hit) begin
      id_pc    = pcf_head;
      id_instr = imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else if (redirect_valid) begin
      // Low target bits are cleared silently; alignment faults are EX's job.
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      // Everything still in flight (old discards plus live requests) must be
      // dropped, less the response that retires in this very cycle.
      discard  <= discard + outstanding - {{(CW-1){1'b0}}, imem_rsp_valid};
    end else begin
      if (accept)   fetch_pc <= fetch_pc + PC_STEP;
      if (rsp_drop) discard  <= discard - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_entry_q (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Tags each live request with its PC; its occupancy is the outstanding count.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_inflight_pc (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (pcf_head),
    .count     (outstanding),
    .full      (pcf_full),
    .empty     (pcf_empty)
  );

  assign unused_flags = &{1'b0, q_full, pcf_full, pcf_empty, redirect_pc[1:0]};

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue. A behavioural memory (in-order request
// list with per-request latency) serves requests; the reference model tracks
// the architectural instruction stream: the next PC ID must see and the next
// address memory must be asked for, both restarting at a redirect target.
// Build with +define+FETCH_BYPASS_EN to expect the zero-latency path.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam int RSP_TO_ID = 0;
`else
  localparam int RSP_TO_ID = 1;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic            id_valid;
  logic            id_ready = 1'b0;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // memory and reference-model state
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          mem_lat  = 1;
  bit          lat_rand = 1'b0;
  bit          rsp_en   = 1'b1;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          n_accept;
  int          n_consume;

  // per-cycle samples
  logic        s_req_valid, s_ready, s_id_valid;
  logic [31:0] s_addr, s_id_pc, s_id_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs at the falling edge, update
  // the memory and reference model, then advance past the rising edge.
  task automatic cycle(input bit redir, input logic [31:0] tgt, input bit idr, input bit rr);
    bit rv;
    redirect_valid = redir;
    redirect_pc    = tgt;
    id_ready       = idr;
    imem_req_ready = rr && (pend_addr.size() < DEPTH);
    rv = 1'b0;
    if (!reset && rsp_en && pend_addr.size() > 0)
      if (pend_due[0] <= cyc) rv = 1'b1;
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? mem_word(pend_addr[0]) : $urandom;

    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_ready     = imem_req_ready;
    s_addr      = imem_addr;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    s_id_instr  = id_instr;

    if (reset) begin
      check("rst_req_valid", s_req_valid, 1'b0);
      check("rst_id_valid", s_id_valid, 1'b0);
      pend_addr.delete();
      pend_due.delete();
      exp_pc  = RESET_PC;
      exp_req = RESET_PC;
    end else begin
      if (rv) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (redir) begin
        check("redir_id_masked", s_id_valid, 1'b0);
        check("redir_no_req", s_req_valid, 1'b0);
        exp_pc  = {tgt[31:2], 2'b00};
        exp_req = {tgt[31:2], 2'b00};
      end else begin
        if (s_req_valid && s_ready) begin
          check("req_addr", s_addr, exp_req);
          pend_addr.push_back(s_addr);
          pend_due.push_back(cyc + (lat_rand ? int'($urandom_range(1, 4)) : mem_lat));
          exp_req += 32'd4;
          n_accept++;
        end
        if (s_id_valid && idr) begin
          check("id_pc", s_id_pc, exp_pc);
          check("id_instr", s_id_instr, mem_word(exp_pc));
          exp_pc += 32'd4;
          n_consume++;
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    reset     = 1'b0;
    n_accept  = 0;
    n_consume = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    bit          prev_stall;
    logic [31:0] prev_addr;
    logic [3:0]  rr_pat;

    // ---- 1: streaming, latency 1, ID always ready ----
    do_reset();
    mem_lat = 1;
    first   = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (i == 0) begin
        check("t1_empty_id_valid", s_id_valid, 1'b0);
        check("t1_empty_id_pc", s_id_pc, 32'h0);
        check("t1_empty_id_instr", s_id_instr, 32'h0);
      end
      if (first < 0 && s_id_valid) first = i;
    end
    check("t1_first_id_cycle", first, 1 + RSP_TO_ID);
    check("t1_one_req_per_cycle", n_accept, 10);
    check("t1_one_instr_per_cycle", n_consume, 10 - (1 + RSP_TO_ID));

    // ---- 2: ID stalled, credits exhaust at DEPTH, then drain ----
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("t2_credit_limit", n_accept, DEPTH);
    check("t2_req_stalled", s_req_valid, 1'b0);
    check("t2_head_valid", s_id_valid, 1'b1);
    check("t2_head_pc", s_id_pc, 32'h0);
    n_accept  = 0;
    n_consume = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("t2_drained_all", n_consume >= DEPTH, 1'b1);
    check("t2_req_resumed", n_accept > 0, 1'b1);

    // ---- 3: latency 3, redirect with 3 requests in flight ----
    do_reset();
    mem_lat = 3;
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    rsp_en = 1'b0;
    cycle(1'b1, 32'h100, 1'b1, 1'b1);
    rsp_en = 1'b1;
    first  = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (i == 0) begin
        check("t3_req_after_redir", s_req_valid, 1'b1);
        check("t3_addr_target", s_addr, 32'h100);
      end
      if (s_id_valid) begin
        first = i;
        check("t3_first_pc", s_id_pc, 32'h100);
        check("t3_first_instr", s_id_instr, mem_word(32'h100));
      end
    end
    check("t3_stale_dropped_cycle", first, 3 + RSP_TO_ID);

    // ---- 4: redirect coinciding with a response and an ID pop ----
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h203, 1'b1, 1'b1);
    check("t4_redir_id_valid", s_id_valid, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("t4_queue_empty", s_id_valid, 1'b0);
    check("t4_empty_pc_zero", s_id_pc, 32'h0);
    check("t4_req_valid", s_req_valid, 1'b1);
    check("t4_aligned_target", s_addr, 32'h200);
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("t4_target_delivered", n_consume > 5, 1'b1);

    // ---- 5: imem_req_ready pattern 1,0,0,1 ----
    do_reset();
    mem_lat    = 2;
    rr_pat     = 4'b1001;
    prev_stall = 1'b0;
    prev_addr  = '0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, 32'h0, 1'b1, rr_pat[i % 4]);
      if (prev_stall) check("t5_addr_hold", s_addr, prev_addr);
      prev_stall = s_req_valid && !s_ready;
      prev_addr  = s_addr;
    end
    check("t5_progress", n_accept > 8, 1'b1);

    // ---- 6: response-to-ID latency from an empty queue ----
    do_reset();
    mem_lat = 3;
    first   = -1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 1'b1, i == 0);
      if (first < 0 && s_id_valid) first = i;
    end
    check("t6_rsp_to_id_latency", first, 3 + RSP_TO_ID);

    // ---- 7: randomized traffic, redirects (incl. wrap), mid-run reset ----
    do_reset();
    lat_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit          redir;
      logic [31:0] tgt;
      if (i == 1500) begin
        rsp_en = 1'b1;
        do_reset();
      end
      rsp_en = ($urandom_range(0, 3) != 0);
      redir  = ($urandom_range(0, 31) == 0);
      tgt    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle(redir, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    check("t7_progress", n_consume > 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_queue
